// File: rtl/soqpsk_pkg.sv
// Shared definitions for the SOQPSK shaper: symbol codes, FSM states and
// the ROM address-width derivation.
package soqpsk_pkg;

  // Precoded ternary symbol codes as they arrive from the precoder.
  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b11;
  localparam logic [1:0] SYM_ILL  = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // ROM address = {symbol history, sample phase}.
  function automatic int addr_width(input int mem_l, input int osr);
    return 2 * mem_l + clog2(osr);
  endfunction

  // The illegal code is carried into the history as a zero symbol.
  function automatic logic [1:0] sym_code(input logic [1:0] data);
    return (data == SYM_ILL) ? SYM_ZERO : data;
  endfunction

endpackage

// File: rtl/soqpsk_rom.sv
// Single-port frequency-pulse ROM with registered address and registered
// output: data for an address presented before edge N appears after edge N+1.
module soqpsk_rom #(
  parameter int    ADDR_W    = 9,
  parameter int    DATA_W    = 14,
  parameter string INIT_FILE = "SOQPSK_2.mif"
) (
  input  logic              clock,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] q
);

  // Contents are bound to this array from INIT_FILE by the memory tools.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  if (INIT_FILE == "") begin : g_blank
    // A ROM built without a contents file reads as all zeros.
    always_ff @(posedge clock) begin
      q <= '0;
    end
  end else begin : g_init
    logic [ADDR_W-1:0] addr_r;

    // Address register followed by the output register, as in the block RAM.
    // NOTE: the array and its read registers are not reset; the shaper's
    // valid pipeline decides when the data is meaningful.
    always_ff @(posedge clock) begin
      addr_r <= addr;
      q      <= mem[addr_r];
    end
  end

endmodule

// File: rtl/soqpsk_shaper.sv
// SOQPSK waveform engine: accepts precoded ternary symbols, walks the
// frequency-pulse ROM at OSR samples per symbol and integrates the ROM
// increments into a wrapping phase word for the NCO/CORDIC.
module soqpsk_shaper
  import soqpsk_pkg::*;
#(
  parameter int    DATA_W    = 14,
  parameter int    OSR       = 8,
  parameter int    MEM_L     = 3,
  parameter int    PHASE_W   = 16,
  parameter string INIT_FILE = "SOQPSK_2.mif"
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     sync_clr,
  input  logic                     sample_en,
  input  logic                     sym_valid,
  input  logic [1:0]               sym_data,
  output logic                     sym_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_incr,
  output logic [PHASE_W-1:0]       out_phase,
  output logic                     underrun,
  output logic                     sym_err
);

  localparam int CNT_W  = clog2(OSR);
  localparam int HIST_W = 2 * MEM_L;
  localparam int ADDR_W = addr_width(MEM_L, OSR);

  state_t                     state, state_n;
  logic [HIST_W-1:0]          hist, hist_n;
  logic [CNT_W-1:0]           cnt, cnt_n;
  logic                       sym_last;
  logic                       issue;
  logic                       set_underrun;
  logic                       set_err;

  logic [ADDR_W-1:0]          addr_q;
  logic                       v_addr, v_rom_addr, v_rom_data;
  logic [DATA_W-1:0]          rom_q;
  logic signed [PHASE_W-1:0]  incr_ext;

  assign sym_last = (cnt == CNT_W'(OSR - 1));
  assign incr_ext = PHASE_W'(signed'(rom_q));

  // Next-state, history shift and symbol handshake.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_n      = state;
    hist_n       = hist;
    cnt_n        = cnt;
    sym_ready    = 1'b0;
    issue        = 1'b0;
    set_underrun = 1'b0;
    set_err      = 1'b0;
    case (state)
      ST_IDLE: begin
        sym_ready = 1'b1;
        if (sym_valid) begin
          hist_n  = HIST_W'({hist, sym_code(sym_data)});
          set_err = (sym_data == SYM_ILL);
          cnt_n   = '0;
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sample_en) begin
          issue = 1'b1;
          if (sym_last) begin
            sym_ready = 1'b1;
            cnt_n     = '0;
            if (sym_valid) begin
              hist_n  = HIST_W'({hist, sym_code(sym_data)});
              set_err = (sym_data == SYM_ILL);
            end else begin
              hist_n       = HIST_W'({hist, SYM_ZERO});
              set_underrun = 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A clearing cycle accepts nothing, so it must not advertise readiness.
    if (sync_clr) sym_ready = 1'b0;
  end

  // Control state and sticky status flags.
  // NOTE: registers use non-blocking assignments so every flop in the design
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      hist     <= '0;
      cnt      <= '0;
      underrun <= 1'b0;
      sym_err  <= 1'b0;
    end else if (sync_clr) begin
      state    <= ST_IDLE;
      hist     <= '0;
      cnt      <= '0;
      underrun <= 1'b0;
      sym_err  <= 1'b0;
    end else begin
      state    <= state_n;
      hist     <= hist_n;
      cnt      <= cnt_n;
      underrun <= underrun | set_underrun;
      sym_err  <= sym_err | set_err;
    end
  end

  // Address register, valid tags through the ROM, and the phase accumulator.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      v_addr     <= 1'b0;
      v_rom_addr <= 1'b0;
      v_rom_data <= 1'b0;
      out_valid  <= 1'b0;
      out_incr   <= '0;
      out_phase  <= '0;
    end else if (sync_clr) begin
      addr_q     <= '0;
      v_addr     <= 1'b0;
      v_rom_addr <= 1'b0;
      v_rom_data <= 1'b0;
      out_valid  <= 1'b0;
      out_incr   <= '0;
      out_phase  <= '0;
    end else begin
      if (issue) addr_q <= {hist, cnt};
      v_addr     <= issue;
      v_rom_addr <= v_addr;
      v_rom_data <= v_rom_addr;
      out_valid  <= v_rom_data;
      if (v_rom_data) begin
        out_incr  <= signed'(rom_q);
        out_phase <= out_phase + incr_ext;
      end
    end
  end

  soqpsk_rom #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clock (clock),
    .addr  (addr_q),
    .q     (rom_q)
  );

endmodule

// File: tb/tb_soqpsk_shaper.sv
// Self-checking bench for soqpsk_shaper: a symbol-level reference model
// predicts every output cycle, and literal expectations pin key values.
module tb_soqpsk_shaper;

  localparam int DATA_W  = 14;
  localparam int OSR     = 8;
  localparam int MEM_L   = 3;
  localparam int PHASE_W = 16;
  localparam int ROM_N   = 512;
  localparam int LAT     = 4;   // negedge samples from strobe to visible output

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               sync_clr = 1'b0;
  logic               sample_en = 1'b0;
  logic               sym_valid = 1'b0;
  logic [1:0]         sym_data = 2'b00;
  logic               sym_ready;
  logic               out_valid;
  logic [DATA_W-1:0]  out_incr;
  logic [PHASE_W-1:0] out_phase;
  logic               underrun;
  logic               sym_err;

  soqpsk_shaper #(
    .DATA_W    (DATA_W),
    .OSR       (OSR),
    .MEM_L     (MEM_L),
    .PHASE_W   (PHASE_W),
    .INIT_FILE ("SOQPSK_2.mif")
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .sync_clr  (sync_clr),
    .sample_en (sample_en),
    .sym_valid (sym_valid),
    .sym_data  (sym_data),
    .sym_ready (sym_ready),
    .out_valid (out_valid),
    .out_incr  (out_incr),
    .out_phase (out_phase),
    .underrun  (underrun),
    .sym_err   (sym_err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int due;
    int incr;
  } exp_t;

  int   rom_model [ROM_N];
  int   m_syms [$];     // symbols consumed so far, newest at the back
  bit   m_run;
  int   m_j;            // sample index within the current symbol
  bit   m_under;
  bit   m_err;
  exp_t exp_q [$];
  int   m_incr;
  int   m_phase;
  int   cyc = 0;

  int obs_incr [$];
  int obs_phase [$];
  int obs_cyc [$];
  int strobe_cyc [$];

  function automatic int sext(input int v);
    return (v >= (1 << (DATA_W - 1))) ? v - (1 << DATA_W) : v;
  endfunction

  function automatic int model_addr();
    int a;
    a = 0;
    for (int i = 0; i < MEM_L; i++) begin
      int idx;
      int c;
      idx = m_syms.size() - 1 - i;
      c = (idx >= 0) ? m_syms[idx] : 0;
      a = a + c * (1 << (2 * i));
    end
    return a * OSR + m_j;
  endfunction

  function automatic int at(input int q [$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic model_clear();
    m_syms.delete();
    exp_q.delete();
    m_run   = 1'b0;
    m_j     = 0;
    m_under = 1'b0;
    m_err   = 1'b0;
    m_incr  = 0;
    m_phase = 0;
  endtask

  task automatic push_sym(input int code);
    m_syms.push_back((code == 2) ? 0 : code);
    if (m_syms.size() > MEM_L) void'(m_syms.pop_front());
  endtask

  task automatic fill_rom(input int mode);
    for (int i = 0; i < ROM_N; i++) begin
      rom_model[i] = (mode == 0) ? i : 'h1FFF;
      dut.u_rom.mem[i] = DATA_W'(rom_model[i]);
    end
  endtask

  // Compare process: outputs are stable at the falling edge; afterwards the
  // model advances using the inputs the next rising edge will sample.
  always @(negedge clock) begin
    bit exp_valid;
    bit exp_ready;
    exp_t e;
    cyc++;
    if (!reset_n) model_clear();
    exp_valid = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    if (exp_valid) begin
      m_incr  = exp_q[0].incr;
      m_phase = (m_phase + sext(m_incr)) % (1 << PHASE_W);
      if (m_phase < 0) m_phase = m_phase + (1 << PHASE_W);
      void'(exp_q.pop_front());
    end
    exp_ready = sync_clr ? 1'b0 : (!m_run ? 1'b1 : (sample_en && m_j == OSR - 1));
    check("out_valid", out_valid, exp_valid);
    check("out_incr", out_incr, m_incr);
    check("out_phase", out_phase, m_phase);
    check("underrun", underrun, m_under);
    check("sym_err", sym_err, m_err);
    check("sym_ready", sym_ready, exp_ready);
    if (out_valid) begin
      obs_incr.push_back(int'(out_incr));
      obs_phase.push_back(int'(out_phase));
      obs_cyc.push_back(cyc);
    end
    if (reset_n) begin
      if (sync_clr) begin
        model_clear();
      end else if (!m_run) begin
        if (sym_valid) begin
          push_sym(int'(sym_data));
          if (sym_data == 2'b10) m_err = 1'b1;
          m_run = 1'b1;
          m_j   = 0;
        end
      end else if (sample_en) begin
        strobe_cyc.push_back(cyc);
        e.due  = cyc + LAT;
        e.incr = rom_model[model_addr()];
        exp_q.push_back(e);
        if (m_j == OSR - 1) begin
          if (sym_valid) begin
            push_sym(int'(sym_data));
            if (sym_data == 2'b10) m_err = 1'b1;
          end else begin
            push_sym(0);
            m_under = 1'b1;
          end
          m_j = 0;
        end else begin
          m_j++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_obs();
    obs_incr.delete();
    obs_phase.delete();
    obs_cyc.delete();
    strobe_cyc.delete();
  endtask

  task automatic send_sym(input logic [1:0] code);
    bit done;
    done      = 1'b0;
    sym_valid = 1'b1;
    sym_data  = code;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock);
      if (sym_ready) done = 1'b1;
      tick();
    end
    sym_valid = 1'b0;
    check("sym_accepted", done, 1);
  endtask

  task automatic pulse_clr();
    sync_clr = 1'b1;
    tick();
    sync_clr = 1'b0;
  endtask

  initial begin
    model_clear();
    fill_rom(0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_phase", out_phase, 0);
    check("rst_out_incr", out_incr, 0);
    check("rst_flags", {underrun, sym_err}, 0);
    check("rst_sym_ready_idle", sym_ready, 1);

    // Single symbol +1, continuous strobes, then a zero is inserted.
    clear_obs();
    sample_en = 1'b1;
    send_sym(2'b01);
    repeat (16) tick();
    sample_en = 1'b0;
    repeat (6) tick();
    check("t1_count", obs_incr.size(), 16);
    check("t1_latency_edges", at(obs_cyc, 0) - at(strobe_cyc, 0) - 1, 3);
    check("t1_incr0", at(obs_incr, 0), 8);
    check("t1_incr7", at(obs_incr, 7), 15);
    check("t1_phase8", at(obs_phase, 7), 92);
    check("t1_fill_incr0", at(obs_incr, 8), 32);
    check("t1_fill_incr7", at(obs_incr, 15), 39);
    check("t1_underrun", underrun, 1);
    repeat (4) tick();
    check("t1_underrun_sticky", underrun, 1);
    pulse_clr();
    check("t1_clr_underrun", underrun, 0);
    check("t1_clr_phase", out_phase, 0);

    // Back-to-back symbols +1, -1, 0.
    clear_obs();
    sample_en = 1'b1;
    send_sym(2'b01);
    send_sym(2'b11);
    send_sym(2'b00);
    repeat (4) tick();
    sample_en = 1'b0;
    repeat (6) tick();
    check("t2_count", obs_incr.size(), 20);
    check("t2_sym2_first", at(obs_incr, 8), 56);
    check("t2_sym2_last", at(obs_incr, 15), 63);
    check("t2_sym3_first", at(obs_incr, 16), 224);
    check("t2_no_underrun", underrun, 0);
    pulse_clr();

    // Accumulator wrap with a constant 0x1FFF pulse.
    fill_rom(1);
    clear_obs();
    sample_en = 1'b1;
    send_sym(2'b01);
    repeat (9) tick();
    sample_en = 1'b0;
    repeat (6) tick();
    check("t3_incr", at(obs_incr, 0), 8191);
    check("t3_phase8", at(obs_phase, 7), 65528);
    check("t3_phase9_wrap", at(obs_phase, 8), 8183);
    pulse_clr();
    fill_rom(0);

    // Illegal code, then sync_clr with samples in flight.
    clear_obs();
    send_sym(2'b10);
    check("t4_sym_err", sym_err, 1);
    sample_en = 1'b1;
    repeat (3) tick();
    sync_clr = 1'b1;
    tick();
    sync_clr  = 1'b0;
    sample_en = 1'b0;
    repeat (6) tick();
    check("t4_no_valid", obs_incr.size(), 0);
    check("t4_err_cleared", sym_err, 0);
    check("t4_phase", out_phase, 0);
    check("t4_idle_ready", sym_ready, 1);

    // Strobe every third cycle with the next symbol waiting.
    clear_obs();
    send_sym(2'b01);
    sym_valid = 1'b1;
    sym_data  = 2'b11;
    for (int i = 0; i < 10; i++) begin
      sample_en = 1'b1;
      tick();
      sample_en = 1'b0;
      tick();
      tick();
    end
    sym_valid = 1'b0;
    repeat (4) tick();
    check("t5_count", obs_incr.size(), 10);
    check("t5_latency_edges", at(obs_cyc, 1) - at(strobe_cyc, 1) - 1, 3);
    check("t5_sym2_first", at(obs_incr, 8), 56);
    check("t5_phase", out_phase, 205);

    // Asynchronous reset between clock edges.
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_phase", out_phase, 0);
    check("t6_async_valid", out_valid, 0);
    check("t6_async_incr", out_incr, 0);
    check("t6_async_ready", sym_ready, 1);
    tick();
    reset_n = 1'b1;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
